// File: rtl/usb_fs_rx.sv
// usb_fs_rx
// Device-side USB full-speed receive engine. Oversamples the raw D+/D- pins
// at 48 MHz (4 samples per bit), recovers bit timing from D+ edges, hunts
// for SYNC, then NRZI-decodes, unstuffs and assembles bytes. It checks the
// PID and the CRC5/CRC16, and detects EOP.
//
// Ports:
//   clock48        48 MHz clock
//   reset          synchronous, active-high
//   usb_dp/usb_dn  raw pad inputs (asynchronous)
//   rx_active      high from SYNC match until packet end/abort
//   rx_pid         PID of the current packet (held until the next SYNC)
//   rx_pid_valid   1-cycle pulse when the PID byte passes its check
//   rx_data        byte following the PID (payload and CRC bytes)
//   rx_data_valid  1-cycle pulse per rx_data byte
//   rx_byte_count  bytes received including the PID, valid at rx_packet_end
//   rx_packet_end  1-cycle pulse when a packet terminates (EOP or abort)
//   rx_packet_ok   no error bits set at rx_packet_end
//   rx_error       {length, crc, stuff, pid}, sticky until the next SYNC
module usb_fs_rx #(
  parameter int MAX_PACKET_BYTES      = 1026,
  parameter int IDLE_BITS_AFTER_RESET = 8
) (
  input  logic        clock48,
  input  logic        reset,
  input  logic        usb_dp,
  input  logic        usb_dn,
  output logic        rx_active,
  output logic [3:0]  rx_pid,
  output logic        rx_pid_valid,
  output logic [7:0]  rx_data,
  output logic        rx_data_valid,
  output logic [10:0] rx_byte_count,
  output logic        rx_packet_end,
  output logic        rx_packet_ok,
  output logic [3:0]  rx_error
);

  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_HUNT      = 3'd1;
  localparam logic [2:0] S_PID       = 3'd2;
  localparam logic [2:0] S_BODY      = 3'd3;
  localparam logic [2:0] S_DISCARD   = 3'd4;

  localparam int IW = $clog2(IDLE_BITS_AFTER_RESET + 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_BITS_AFTER_RESET - 1);
  localparam logic [10:0]   BYTE_LIMIT = 11'(MAX_PACKET_BYTES + 1);

  logic          dp_meta, dp_sync, dn_meta, dn_sync, dp_prev;
  logic [1:0]    phase;
  logic [2:0]    state;
  logic [IW-1:0] idle_count;
  logic          rearm;
  logic          prev_level;
  logic [6:0]    hunt_shift;
  logic [2:0]    ones_count;
  logic [2:0]    bit_count;
  logic [6:0]    byte_shift;
  logic [4:0]    crc5;
  logic [15:0]   crc16;

  logic          sample, line_j, line_k, line_se0, nrzi_bit;
  logic          stuff_slot, byte_done;
  logic [7:0]    assembled;
  logic [4:0]    crc5_next;
  logic [15:0]   crc16_next;
  logic          eop_len_err, eop_crc_err;
  logic [3:0]    eop_error;

  // Two-flop synchronizers; dp_prev feeds the edge detector for clock recovery.
  always_ff @(posedge clock48) begin
    if (reset) begin
      dp_meta <= 1'b0;
      dp_sync <= 1'b0;
      dn_meta <= 1'b0;
      dn_sync <= 1'b0;
      dp_prev <= 1'b0;
    end else begin
      dp_meta <= usb_dp;
      dp_sync <= dp_meta;
      dn_meta <= usb_dn;
      dn_sync <= dn_meta;
      dp_prev <= dp_sync;
    end
  end

  // Every D+ edge realigns the phase, so the sample lands mid-to-late in the bit.
  always_ff @(posedge clock48) begin
    if (reset)                  phase <= 2'd0;
    else if (dp_sync != dp_prev) phase <= 2'd0;
    else                        phase <= phase + 2'd1;
  end

  assign sample     = (phase == 2'd2);
  assign line_j     = dp_sync & ~dn_sync;
  assign line_k     = ~dp_sync & dn_sync;
  assign line_se0   = ~(line_j | line_k);
  assign nrzi_bit   = (dp_sync == prev_level);
  assign stuff_slot = (ones_count == 3'd6);
  assign byte_done  = (bit_count == 3'd7);
  assign assembled  = {nrzi_bit, byte_shift};
  assign crc5_next  = {crc5[3:0], 1'b0} ^ ((nrzi_bit ^ crc5[4]) ? 5'b00101 : 5'b00000);
  assign crc16_next = {crc16[14:0], 1'b0} ^ ((nrzi_bit ^ crc16[15]) ? 16'h8005 : 16'h0000);

  // Length/CRC verdict for an SE0 seen while the packet is still live.
  // An EOP during the PID byte can never be a complete packet.
  always_comb begin
    eop_len_err = 1'b0;
    eop_crc_err = 1'b0;
    if (state == S_PID) begin
      eop_len_err = 1'b1;
    end else begin
      if (bit_count != 3'd0) eop_len_err = 1'b1;
      case (rx_pid[1:0])
        2'b01: begin
          if (rx_byte_count != 11'd3) eop_len_err = 1'b1;
          if (crc5 != 5'b01100)       eop_crc_err = 1'b1;
        end
        2'b11: begin
          if (rx_byte_count < 11'd3)  eop_len_err = 1'b1;
          if (crc16 != 16'h800D)      eop_crc_err = 1'b1;
        end
        default: begin
          if (rx_byte_count != 11'd1) eop_len_err = 1'b1;
        end
      endcase
    end
  end

  assign eop_error = rx_error | {eop_len_err, eop_crc_err, 2'b00};

  always_ff @(posedge clock48) begin
    if (reset) begin
      state         <= S_WAIT_IDLE;
      idle_count    <= '0;
      rearm         <= 1'b0;
      prev_level    <= 1'b1;
      hunt_shift    <= 7'h7F;
      ones_count    <= 3'd0;
      bit_count     <= 3'd0;
      byte_shift    <= 7'd0;
      crc5          <= 5'h1F;
      crc16         <= 16'hFFFF;
      rx_active     <= 1'b0;
      rx_pid        <= 4'd0;
      rx_pid_valid  <= 1'b0;
      rx_data       <= 8'd0;
      rx_data_valid <= 1'b0;
      rx_byte_count <= 11'd0;
      rx_packet_end <= 1'b0;
      rx_packet_ok  <= 1'b0;
      rx_error      <= 4'd0;
    end else begin
      rx_pid_valid  <= 1'b0;
      rx_data_valid <= 1'b0;
      rx_packet_end <= 1'b0;
      if (sample) begin
        case (state)
          // rearm lets the J that closes an EOP satisfy the idle requirement;
          // the trailing SE0 of that EOP must not cancel it.
          S_WAIT_IDLE: begin
            prev_level <= 1'b1;
            hunt_shift <= 7'h7F;
            if (line_j) begin
              if (rearm || idle_count == IDLE_LAST) begin
                state      <= S_HUNT;
                idle_count <= '0;
                rearm      <= 1'b0;
              end else begin
                idle_count <= idle_count + 1'b1;
              end
            end else if (!(rearm && line_se0)) begin
              idle_count <= '0;
              rearm      <= 1'b0;
            end
          end

          S_HUNT: begin
            if (line_se0) begin
              prev_level <= 1'b1;
              hunt_shift <= 7'h7F;
            end else begin
              prev_level <= dp_sync;
              hunt_shift <= {hunt_shift[5:0], nrzi_bit};
              if ({hunt_shift, nrzi_bit} == 8'h01) begin
                state         <= S_PID;
                rx_active     <= 1'b1;
                rx_error      <= 4'd0;
                rx_packet_ok  <= 1'b0;
                rx_byte_count <= 11'd0;
                ones_count    <= 3'd1;
                bit_count     <= 3'd0;
              end
            end
          end

          S_PID, S_BODY: begin
            if (line_se0) begin
              rx_packet_end <= 1'b1;
              rx_active     <= 1'b0;
              rx_error      <= eop_error;
              rx_packet_ok  <= ~|eop_error;
              state         <= S_WAIT_IDLE;
              rearm         <= 1'b1;
              idle_count    <= '0;
            end else begin
              prev_level <= dp_sync;
              if (stuff_slot) begin
                // Stuffed bit: dropped without touching byte alignment.
                ones_count <= 3'd0;
                if (nrzi_bit) begin
                  rx_error[1] <= 1'b1;
                  state       <= S_DISCARD;
                end
              end else begin
                ones_count <= nrzi_bit ? ones_count + 3'd1 : 3'd0;
                byte_shift <= assembled[7:1];
                bit_count  <= bit_count + 3'd1;
                if (state == S_BODY) begin
                  crc5  <= crc5_next;
                  crc16 <= crc16_next;
                end
                if (byte_done) begin
                  if (state == S_PID) begin
                    if (assembled[3:0] == ~assembled[7:4]) begin
                      rx_pid        <= assembled[3:0];
                      rx_pid_valid  <= 1'b1;
                      rx_byte_count <= 11'd1;
                      crc5          <= 5'h1F;
                      crc16         <= 16'hFFFF;
                      state         <= S_BODY;
                    end else begin
                      rx_error[0] <= 1'b1;
                      state       <= S_DISCARD;
                    end
                  end else if (rx_byte_count == BYTE_LIMIT - 11'd1) begin
                    rx_error[3]   <= 1'b1;
                    rx_byte_count <= BYTE_LIMIT;
                    state         <= S_DISCARD;
                  end else begin
                    rx_data       <= assembled;
                    rx_data_valid <= 1'b1;
                    rx_byte_count <= rx_byte_count + 11'd1;
                  end
                end
              end
            end
          end

          S_DISCARD: begin
            if (line_se0) begin
              rx_packet_end <= 1'b1;
              rx_active     <= 1'b0;
              rx_packet_ok  <= ~|rx_error;
              state         <= S_WAIT_IDLE;
              rearm         <= 1'b1;
              idle_count    <= '0;
            end
          end

          default: state <= S_WAIT_IDLE;
        endcase
      end
    end
  end

endmodule
